// File: rtl/morse_pkg.sv
// Shared types and default unit timing for the Morse symbol sequencer.
package morse_pkg;

  typedef enum logic [1:0] {
    SYM_DOT  = 2'b00,
    SYM_DASH = 2'b01,
    SYM_CGAP = 2'b10,
    SYM_WGAP = 2'b11
  } sym_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } seq_state_t;

  localparam int DEF_DOT_UNITS      = 1;
  localparam int DEF_DASH_UNITS     = 3;
  localparam int DEF_ELEM_GAP_UNITS = 1;
  localparam int DEF_CHAR_GAP_UNITS = 3;
  localparam int DEF_WORD_GAP_UNITS = 7;
  localparam int DEF_FARN_EXTRA     = 2;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/morse_symbol_sequencer_if.sv
// Symbol handshake between the character encoder (master) and the sequencer (slave).
interface morse_symbol_sequencer_if;
  import morse_pkg::*;

  logic sym_valid;
  sym_t sym;
  logic sym_ready;

  modport master (output sym_valid, output sym, input sym_ready);
  modport slave  (input sym_valid, input sym, output sym_ready);
endinterface

// File: rtl/morse_unit_counter.sv
// Loadable down-counter of unit ticks; last_o is registered and marks the tick that
// consumed the final unit. A load takes priority over a coincident tick.
module morse_unit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         tick_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         last_q, last_d;

  always_comb begin
    cnt_d  = cnt_q;
    last_d = 1'b0;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d  = cnt_q - 1'b1;
      last_d = (cnt_q == W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign last_o = last_q;

endmodule

// File: rtl/morse_symbol_sequencer.sv
// Plays one Morse symbol per handshake on the unit tick and gates the prescaler.
// Define MORSE_SEQ_FARNSWORTH_EN to stretch every gap symbol by FARN_EXTRA units.
module morse_symbol_sequencer
  import morse_pkg::*;
#(
  parameter int DOT_UNITS      = DEF_DOT_UNITS,
  parameter int DASH_UNITS     = DEF_DASH_UNITS,
  parameter int ELEM_GAP_UNITS = DEF_ELEM_GAP_UNITS,
  parameter int CHAR_GAP_UNITS = DEF_CHAR_GAP_UNITS,
  parameter int WORD_GAP_UNITS = DEF_WORD_GAP_UNITS,
  parameter int FARN_EXTRA     = DEF_FARN_EXTRA
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  morse_symbol_sequencer_if.slave  sym_if,
  output logic                     key_out,
  output logic                     busy,
  output logic                     done,
  output logic                     presc_ce
);

  localparam int MAX_UNITS = max_of(max_of(max_of(DOT_UNITS, DASH_UNITS), ELEM_GAP_UNITS),
                                    max_of(CHAR_GAP_UNITS, WORD_GAP_UNITS) + FARN_EXTRA);
  localparam int W = $clog2(MAX_UNITS + 1);

`ifdef MORSE_SEQ_FARNSWORTH_EN
  localparam int GAP_PAD = FARN_EXTRA;
`else
  localparam int GAP_PAD = 0;
`endif

  // Gap symbols only add the remainder: the previous element already emitted its ELEM gap.
  localparam logic [W-1:0] DOT_LOAD  = W'(DOT_UNITS);
  localparam logic [W-1:0] DASH_LOAD = W'(DASH_UNITS);
  localparam logic [W-1:0] ELEM_LOAD = W'(ELEM_GAP_UNITS);
  localparam logic [W-1:0] CGAP_LOAD = W'(CHAR_GAP_UNITS - ELEM_GAP_UNITS + GAP_PAD);
  localparam logic [W-1:0] WGAP_LOAD = W'(WORD_GAP_UNITS - ELEM_GAP_UNITS + GAP_PAD);

  if (DOT_UNITS < 1 || DASH_UNITS < 1 || ELEM_GAP_UNITS < 1 || FARN_EXTRA < 0 ||
      CHAR_GAP_UNITS <= ELEM_GAP_UNITS || WORD_GAP_UNITS <= ELEM_GAP_UNITS) begin : g_param_err
    $error("morse_symbol_sequencer: illegal unit parameters");
  end

  seq_state_t   state_q, state_d;
  logic         key_q, key_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         ready_q, ready_d;
  logic         load;
  logic [W-1:0] load_val;
  logic         last;

  morse_unit_counter #(.W(W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .load_val_i (load_val),
    .tick_i     (tick),
    .last_o     (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = '0;
    case (state_q)
      IDLE: begin
        if (sym_if.sym_valid && ready_q) begin
          load = 1'b1;
          case (sym_if.sym)
            SYM_DOT:  begin state_d = MARK;  load_val = DOT_LOAD;  end
            SYM_DASH: begin state_d = MARK;  load_val = DASH_LOAD; end
            SYM_CGAP: begin state_d = SPACE; load_val = CGAP_LOAD; end
            default:  begin state_d = SPACE; load_val = WGAP_LOAD; end
          endcase
        end
      end
      MARK: begin
        if (last) begin
          state_d  = SPACE;
          load     = 1'b1;
          load_val = ELEM_LOAD;
        end
      end
      SPACE: begin
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    key_d   = (state_d == MARK);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
    done_d  = (state_q == SPACE) && last;
  end

  assign key_out          = key_q;
  assign busy             = busy_q;
  assign presc_ce         = busy_q;
  assign done             = done_q;
  assign sym_if.sym_ready = ready_q;

endmodule
